// File: rtl/mem_bus_ctrl.sv
// Memory-side bus controller: splits CPU accesses between external RAM and an MMIO
// window (TX byte FIFO, prescaled 16-bit timer with compare, status register).
module mem_bus_ctrl #(
  parameter int          FIFO_DEPTH = 8,
  parameter int          PRESCALE   = 16,
  parameter logic [15:0] MMIO_BASE  = 16'hF000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_mem_we,
  input  logic [15:0] cpu_mem_addr,
  input  logic [15:0] cpu_mem_in,
  output logic [15:0] cpu_mem_out,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [SW-1:0] PRE_LAST = SW'(PRESCALE - 1);

  logic          mmio_sel;
  logic [7:0]    off;
  logic          wr_tx, wr_stat, wr_tim, wr_cmp;
  logic          fifo_empty, fifo_full, pop, push, tick;
  logic          ovf_set, match_set;
  logic [15:0]   timer_inc, status, mmio_rdata;
  logic [3:0]    occ;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [15:0]   timer_q, timer_d, cmp_q, cmp_d;
  logic [SW-1:0] pre_q, pre_d;
  logic          ovf_q, ovf_d, match_q, match_d, irq_en_q, irq_en_d;

  assign mmio_sel  = (cpu_mem_addr[15:8] == MMIO_BASE[15:8]);
  assign off       = cpu_mem_addr[7:0];
  assign wr_tx     = cpu_mem_we & mmio_sel & (off == 8'h00);
  assign wr_stat   = cpu_mem_we & mmio_sel & (off == 8'h01);
  assign wr_tim    = cpu_mem_we & mmio_sel & (off == 8'h02);
  assign wr_cmp    = cpu_mem_we & mmio_sel & (off == 8'h03);

  assign ram_we    = cpu_mem_we & ~mmio_sel & rst_n;
  assign ram_addr  = cpu_mem_addr;
  assign ram_wdata = cpu_mem_in;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  // A pop frees the slot in the same edge, so a push into a full FIFO is accepted then.
  assign pop        = ~fifo_empty & tx_ready;
  assign push       = wr_tx & (~fifo_full | pop);
  assign tick       = (pre_q == PRE_LAST);
  assign timer_inc  = timer_q + 16'd1;

  assign tx_valid  = ~fifo_empty;
  assign tx_data   = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign timer_irq = match_q & irq_en_q;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    timer_d   = timer_q;
    pre_d     = pre_q;
    cmp_d     = cmp_q;
    irq_en_d  = irq_en_q;
    match_set = 1'b0;
    ovf_set   = wr_tx & fifo_full & ~pop;
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    if (wr_tim) begin
      timer_d = cpu_mem_in;
      pre_d   = '0;
    end else if (tick) begin
      timer_d   = timer_inc;
      pre_d     = '0;
      match_set = (timer_inc == cmp_q);
    end else begin
      pre_d = pre_q + SW'(1);
    end
    if (wr_cmp)  cmp_d    = cpu_mem_in;
    if (wr_stat) irq_en_d = cpu_mem_in[4];
    // Clear first, then set, so a same-cycle event survives a write-1-to-clear.
    ovf_d   = (ovf_q   & ~(wr_stat & cpu_mem_in[2])) | ovf_set;
    match_d = (match_q & ~(wr_stat & cpu_mem_in[3])) | match_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      pre_q    <= '0;
      cmp_q    <= 16'hFFFF;
      ovf_q    <= 1'b0;
      match_q  <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      pre_q    <= pre_d;
      cmp_q    <= cmp_d;
      ovf_q    <= ovf_d;
      match_q  <= match_d;
      irq_en_q <= irq_en_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cpu_mem_in[7:0];
  end

  always_comb begin
    occ = (32'(count_q) > 15) ? 4'hF : 4'(count_q);
    status = {4'h0, occ, 3'b000, irq_en_q, match_q, ovf_q, fifo_full, fifo_empty};
    case (off)
      8'h01:   mmio_rdata = status;
      8'h02:   mmio_rdata = timer_q;
      8'h03:   mmio_rdata = cmp_q;
      default: mmio_rdata = 16'h0000;
    endcase
    cpu_mem_out = mmio_sel ? mmio_rdata : ram_rdata;
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: decode table, directed FIFO/timer/reset
// sequences and a randomized run against a queue-based reference model.
module tb_mem_bus_ctrl;

  localparam int DEPTH    = 8;
  localparam int PRESCALE = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_mem_we;
  logic [15:0] cpu_mem_addr, cpu_mem_in, cpu_mem_out;
  logic        ram_we;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, timer_irq;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_ctrl #(.FIFO_DEPTH(DEPTH), .PRESCALE(PRESCALE), .MMIO_BASE(16'hF000)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_mem_we(cpu_mem_we), .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_in(cpu_mem_in), .cpu_mem_out(cpu_mem_out), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Reference model: byte queue plus plain counters.
  logic [7:0]  m_q[$];
  logic [15:0] m_timer, m_cmp;
  int          m_since;
  bit          m_ovf, m_match, m_irqen;

  task automatic m_reset();
    m_q.delete();
    m_timer = 16'h0; m_cmp = 16'hFFFF; m_since = 0;
    m_ovf = 0; m_match = 0; m_irqen = 0;
  endtask

  function automatic logic [15:0] m_status();
    logic [3:0] occ;
    occ = (m_q.size() > 15) ? 4'hF : 4'(m_q.size());
    return {4'h0, occ, 3'b000, m_irqen, m_match, m_ovf, m_q.size() == DEPTH, m_q.size() == 0};
  endfunction

  function automatic logic [15:0] m_read(logic [15:0] a, logic [15:0] rd);
    if (a[15:8] != 8'hF0) return rd;
    case (a[7:0])
      8'h01:   return m_status();
      8'h02:   return m_timer;
      8'h03:   return m_cmp;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic m_step(bit we, logic [15:0] a, logic [15:0] d, bit rdy);
    bit mm        = (a[15:8] == 8'hF0);
    bit ovf_set   = 0;
    bit match_set = 0;
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    if (we && mm && a[7:0] == 8'h00) begin
      if (m_q.size() < DEPTH) m_q.push_back(d[7:0]);
      else ovf_set = 1;
    end
    if (we && mm && a[7:0] == 8'h02) begin
      m_timer = d;
      m_since = 0;
    end else begin
      m_since++;
      if (m_since % PRESCALE == 0) begin
        m_timer = m_timer + 16'd1;
        if (m_timer == m_cmp) match_set = 1;
      end
    end
    if (we && mm && a[7:0] == 8'h03) m_cmp = d;
    if (we && mm && a[7:0] == 8'h01) begin
      if (d[2]) m_ovf = 0;
      if (d[3]) m_match = 0;
      m_irqen = d[4];
    end
    m_ovf   = m_ovf   | ovf_set;
    m_match = m_match | match_set;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(bit we, logic [15:0] a, logic [15:0] d, bit rdy, logic [15:0] rd);
    @(negedge clk);
    cpu_mem_we = we; cpu_mem_addr = a; cpu_mem_in = d; tx_ready = rdy; ram_rdata = rd;
    #1;
  endtask

  task automatic step();
    chk("rd_data",   cpu_mem_out, m_read(cpu_mem_addr, ram_rdata));
    chk("tx_valid",  {15'h0, tx_valid}, {15'h0, m_q.size() != 0});
    chk("tx_data",   {8'h0, tx_data}, {8'h0, (m_q.size() != 0) ? m_q[0] : 8'h00});
    chk("timer_irq", {15'h0, timer_irq}, {15'h0, m_match && m_irqen});
    chk("ram_we",    {15'h0, ram_we}, {15'h0, cpu_mem_we && cpu_mem_addr[15:8] != 8'hF0});
    chk("ram_addr",  ram_addr, cpu_mem_addr);
    chk("ram_wdata", ram_wdata, cpu_mem_in);
    @(posedge clk);
    m_step(cpu_mem_we, cpu_mem_addr, cpu_mem_in, tx_ready);
  endtask

  task automatic cyc(bit we, logic [15:0] a, logic [15:0] d, bit rdy);
    drive(we, a, d, rdy, 16'($urandom));
    step();
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] rdata;
    logic [15:0] exp_out;
    logic        exp_ram_we;
  } vec_t;

  vec_t vtab[9];

  initial begin
    vtab[0] = '{1'b0, 16'hF001, 16'h0000, 16'h1111, 16'h0001, 1'b0};
    vtab[1] = '{1'b0, 16'hF003, 16'h0000, 16'h1111, 16'hFFFF, 1'b0};
    vtab[2] = '{1'b0, 16'hF000, 16'h0000, 16'h1111, 16'h0000, 1'b0};
    vtab[3] = '{1'b0, 16'hF0FF, 16'h0000, 16'h1111, 16'h0000, 1'b0};
    vtab[4] = '{1'b1, 16'h0010, 16'h1234, 16'hBEEF, 16'hBEEF, 1'b1};
    vtab[5] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0};
    vtab[6] = '{1'b0, 16'hEFFF, 16'h0000, 16'h1357, 16'h1357, 1'b0};
    vtab[7] = '{1'b1, 16'hF0FF, 16'hAAAA, 16'h2468, 16'h0000, 1'b0};
    vtab[8] = '{1'b1, 16'hF100, 16'h0042, 16'h3579, 16'h3579, 1'b1};

    rst_n = 1'b0; cpu_mem_we = 0; cpu_mem_addr = 0; cpu_mem_in = 0; ram_rdata = 0; tx_ready = 0;
    m_reset();
    #1;
    chk("rst_tx_valid", {15'h0, tx_valid}, 16'h0);
    chk("rst_tx_data", {8'h0, tx_data}, 16'h0);
    chk("rst_irq", {15'h0, timer_irq}, 16'h0);
    repeat (3) @(posedge clk);
    drive(1'b1, 16'h0010, 16'h5A5A, 1'b0, 16'h0);
    chk("ram_we_in_reset", {15'h0, ram_we}, 16'h0);
    rst_n = 1'b1;
    #1;

    // Decode / RAM path table
    for (int i = 0; i < 9; i++) begin
      if (i > 0) drive(vtab[i].we, vtab[i].addr, vtab[i].din, 1'b0, vtab[i].rdata);
      else begin
        cpu_mem_we = vtab[0].we; cpu_mem_addr = vtab[0].addr; cpu_mem_in = vtab[0].din;
        ram_rdata = vtab[0].rdata; #1;
      end
      chk($sformatf("vec%0d_out", i), cpu_mem_out, vtab[i].exp_out);
      chk($sformatf("vec%0d_ram_we", i), {15'h0, ram_we}, {15'h0, vtab[i].exp_ram_we});
      step();
    end

    // FIFO fill, overflow, ordered drain
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'hF000, 16'h0041 + 16'(i), 1'b0, 16'h0);
      chk("txdata_wr_ram_we", {15'h0, ram_we}, 16'h0);
      step();
    end
    drive(1'b0, 16'hF001, 16'h0, 1'b0, 16'h0);
    chk("status_full", cpu_mem_out, 16'h0802);
    step();
    cyc(1'b1, 16'hF000, 16'h0049, 1'b0);
    drive(1'b0, 16'hF001, 16'h0, 1'b0, 16'h0);
    chk("status_ovf", cpu_mem_out, 16'h0806);
    step();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 16'hF001, 16'h0, 1'b1, 16'h0);
      chk("drain_byte", {8'h0, tx_data}, 16'h0041 + 16'(i));
      step();
    end
    drive(1'b0, 16'hF001, 16'h0, 1'b1, 16'h0);
    chk("drained_valid", {15'h0, tx_valid}, 16'h0);
    chk("status_empty_ovf", cpu_mem_out, 16'h0005);
    step();
    cyc(1'b1, 16'hF001, 16'h0004, 1'b0);
    drive(1'b0, 16'hF001, 16'h0, 1'b0, 16'h0);
    chk("status_ovf_clr", cpu_mem_out, 16'h0001);
    step();

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'hF000, 16'h0061 + 16'(i), 1'b0);
    cyc(1'b1, 16'hF000, 16'h0055, 1'b1);
    drive(1'b0, 16'hF001, 16'h0, 1'b0, 16'h0);
    chk("status_pushpop_full", cpu_mem_out, 16'h0802);
    step();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 16'h0000, 16'h0, 1'b1, 16'h0);
      chk("pushpop_byte", {8'h0, tx_data}, (i < 7) ? 16'h0062 + 16'(i) : 16'h0055);
      step();
    end

    // Timer compare and IRQ
    cyc(1'b1, 16'hF002, 16'h0000, 1'b0);
    cyc(1'b1, 16'hF003, 16'h0003, 1'b0);
    cyc(1'b1, 16'hF001, 16'h0010, 1'b0);
    repeat (46) cyc(1'b0, 16'h0000, 16'h0, 1'b0);
    drive(1'b0, 16'hF002, 16'h0, 1'b0, 16'h0);
    chk("timer_at_cmp", cpu_mem_out, 16'h0003);
    chk("irq_set", {15'h0, timer_irq}, 16'h0001);
    step();
    drive(1'b0, 16'hF001, 16'h0, 1'b0, 16'h0);
    chk("status_match", cpu_mem_out, 16'h0019);
    step();
    cyc(1'b1, 16'hF001, 16'h0008, 1'b0);
    drive(1'b0, 16'hF001, 16'h0, 1'b0, 16'h0);
    chk("irq_clr", {15'h0, timer_irq}, 16'h0);
    chk("status_match_clr", cpu_mem_out, 16'h0001);
    step();
    cyc(1'b1, 16'hF002, 16'h0003, 1'b0);
    drive(1'b0, 16'hF001, 16'h0, 1'b0, 16'h0);
    chk("load_no_match", cpu_mem_out, 16'h0001);
    step();

    // Timer wrap
    cyc(1'b1, 16'hF002, 16'hFFFF, 1'b0);
    repeat (15) cyc(1'b0, 16'h0000, 16'h0, 1'b0);
    drive(1'b0, 16'hF002, 16'h0, 1'b0, 16'h0);
    chk("timer_pre_wrap", cpu_mem_out, 16'hFFFF);
    step();
    drive(1'b0, 16'hF002, 16'h0, 1'b0, 16'h0);
    chk("timer_wrap", cpu_mem_out, 16'h0000);
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic [15:0] a, d;
      r = $urandom_range(0, 11);
      d = 16'($urandom);
      case (r)
        0, 1, 2: a = 16'hF000;
        3:       a = 16'hF001;
        4:       begin a = 16'hF002; d = 16'($urandom_range(0, 6)); end
        5:       begin a = 16'hF003; d = 16'($urandom_range(0, 8)); end
        6:       a = {8'hF0, 8'($urandom_range(4, 255))};
        7:       a = {8'hF1, 8'($urandom)};
        8:       a = {8'hEF, 8'($urandom)};
        default: a = 16'($urandom);
      endcase
      drive($urandom_range(0, 2) == 0, a, d, $urandom_range(0, 1) == 1, 16'($urandom));
      step();
    end

    // Asynchronous reset in the middle of a drain
    repeat (10) cyc(1'b0, 16'h0000, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'hF000, 16'h0031 + 16'(i), 1'b0);
    drive(1'b0, 16'h0010, 16'h0, 1'b1, 16'h0);
    chk("middrain_valid", {15'h0, tx_valid}, 16'h0001);
    step();
    drive(1'b1, 16'h0010, 16'h7777, 1'b1, 16'h0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {15'h0, tx_valid}, 16'h0);
    chk("async_rst_data", {8'h0, tx_data}, 16'h0);
    chk("async_rst_ram_we", {15'h0, ram_we}, 16'h0);
    m_reset();
    repeat (2) @(posedge clk);
    drive(1'b0, 16'hF001, 16'h0, 1'b0, 16'h0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_status", cpu_mem_out, 16'h0001);
    step();
    drive(1'b0, 16'hF002, 16'h0, 1'b0, 16'h0);
    chk("post_rst_timer", cpu_mem_out, 16'h0000);
    step();
    repeat (20) cyc($urandom_range(0, 1) == 1, {8'hF0, 8'($urandom_range(0, 3))}, 16'($urandom), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Memory-side bus controller directly downstream of the CPU's memory port (mem_we / mem_addr / mem_in, returns mem_out).
- Decodes each CPU access to one of two targets:
  - external word RAM;
  - a 256-word MMIO window holding a console TX FIFO, a 16-bit prescaled timer with compare, and a status register.
- Drains the TX FIFO over a valid/ready byte stream.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of two, at least 2.
- PRESCALE, 16, clk cycles per timer increment; at least 1.
- MMIO_BASE, 16'hF000, base of MMIO window; low 8 bits must be zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_mem_we  in  1  CPU write strobe.
- cpu_mem_addr  in  16  CPU word address.
- cpu_mem_in  in  16  CPU write data.
- cpu_mem_out  out  16  read data to CPU.
- ram_we  out  1  RAM write enable.
- ram_addr  out  16  RAM address (cpu_mem_addr passthrough).
- ram_wdata  out  16  RAM write data (cpu_mem_in passthrough).
- ram_rdata  in  16  RAM read data, combinational from ram_addr.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts byte.
- timer_irq  out  1  level, equals match flag AND irq_en.

Behaviour:
- Decode:
  - mmio_sel = (cpu_mem_addr[15:8] == MMIO_BASE[15:8]).
  - ram_we = cpu_mem_we & ~mmio_sel & rst_n.
  - ram_addr and ram_wdata are always passthrough.
- Reads are combinational, zero wait states:
  - cpu_mem_out = ram_rdata when ~mmio_sel, else the MMIO register value.
- All register writes take effect on the rising clk edge where cpu_mem_we=1.
- MMIO map (word offset):
  - 0x00 TXDATA. Write pushes cpu_mem_in[7:0]. Read returns 0.
  - 0x01 STATUS. Read layout:
    - bit0 empty, bit1 full, bit2 overflow (sticky), bit3 match (sticky), bit4 irq_en;
    - bits[11:8] occupancy count, saturated to 15;
    - all other bits 0.
  - 0x01 STATUS write:
    - bit2=1 clears overflow; bit3=1 clears match (write-1-to-clear);
    - bit4 loads irq_en.
  - 0x02 TIMER. Read returns current count. Write loads the count and resets the prescale counter to 0.
  - 0x03 TIMER_CMP. Read/write compare value.
  - Other offsets read 0; writes to them are ignored.
- TX FIFO:
  - Circular buffer with read/write pointers and a count.
  - tx_valid = (count != 0). tx_data = mem[rd_ptr], or 0 when empty.
  - A pop occurs on the edge where tx_valid & tx_ready.
  - A push occurs on a TXDATA write.
  - Push while full with no pop in the same cycle: data dropped, overflow set, count unchanged.
  - Push and pop in the same cycle while full: push accepted, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: push only. tx_valid rises the next cycle, so latency is 1 clk from write to tx_valid.
  - tx_data must stay stable while tx_valid=1 and tx_ready=0.
  - Pointers wrap modulo FIFO_DEPTH.
- Timer:
  - The prescale counter counts 0..PRESCALE-1. On reaching PRESCALE-1 it wraps to 0 and issues a tick.
  - On a tick, timer = timer+1 (16-bit wrap 0xFFFF -> 0x0000).
  - match is set on the edge where timer increments to a value equal to TIMER_CMP. Loads via TIMER write never set match.
  - A TIMER write in the same cycle as a tick: the write wins and no increment occurs.
  - Match set and STATUS clear in the same cycle: set wins.
- Reset (asynchronous, any time, including mid-drain):
  - FIFO empty, pointers 0, tx_valid=0, tx_data=0.
  - timer=0, prescale counter=0, TIMER_CMP=16'hFFFF.
  - overflow=0, match=0, irq_en=0, timer_irq=0.
  - ram_we=0 while rst_n=0.
  - FIFO storage contents need not be cleared.

Test Plan:
- Reset, then RAM path: write 0x1234 to addr 0x0010 -> ram_we=1 that cycle. Drive ram_rdata=0xBEEF for a read of 0x0010 -> cpu_mem_out=0xBEEF. A write to 0xF000 -> ram_we=0.
- FIFO fill and overflow, tx_ready=0: write 0x41..0x48 to 0xF000 -> STATUS=0x0802 (full, count 8). Write 0x49 -> STATUS bit2=1 and count still 8. Set tx_ready=1 -> bytes 0x41..0x48 emerge in order; then tx_valid=0 and STATUS bit0=1. Write STATUS 0x0004 -> bit2 cleared.
- Full with simultaneous push and pop: with FIFO full and tx_ready=1, write 0x55 in the same cycle -> no overflow, count stays 8, and 0x55 emerges last.
- Timer and IRQ, PRESCALE=16: write TIMER_CMP=3, STATUS=0x0010 -> after 48 clks TIMER reads 3, STATUS bit3=1, timer_irq=1. Write STATUS 0x0008 -> timer_irq=0. A TIMER write of 0x0003 does not set match.
- Timer wrap: write TIMER=0xFFFF -> after 16 clks it reads 0x0000.
- Async reset mid-drain: assert rst_n=0 between clock edges with 3 bytes queued -> tx_valid=0 immediately. After release, STATUS=0x0001 and TIMER=0.
